alu_muldiv_ctrl: RTL and testbench
==================================

Name: alu_muldiv_ctrl

Overview:
- Next-generation EX-stage ALU control for the MIPS core.
- Decodes ALUOp/FuncCode into the 4-bit ALU control code.
- Adds a parametrised iterative multiply/divide unit with HI/LO registers.
- Drives a stall to the pipeline while a multi-cycle operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (even, 8..64).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue  in  1  valid instruction present in EX this cycle.
- alu_op  in  4  main-decoder ALUOp; 4'b1111 = R-type, use func_code.
- func_code  in  6  instruction funct field.
- rs_val  in  WIDTH  forwarded rs operand.
- rt_val  in  WIDTH  forwarded rt operand.
- alu_ctrl  out  4  ALU operation code, combinational.
- hilo_sel  out  1  EX result comes from hilo_rdata (MFHI/MFLO).
- hilo_rdata  out  WIDTH  HI (MFHI) or LO (MFLO), else 0.
- busy  out  1  mul/div engine active.
- stall  out  1  hold IF/ID/EX this cycle.

Behaviour:
- Reset: all outputs and state are driven by rst, asynchronously.
  - HI=0, LO=0, state=IDLE, count=0, busy=0.
  - stall=0 and hilo_sel=0 while rst=1.
- alu_ctrl, combinational:
  - alu_op!=4'b1111 → alu_op passes through.
  - R-type functs map to codes: SLL 000000→3, SRL 000010→4, SRA 000011→D, ADD 100000→2, ADDU 100001→8, SUB 100010→6, SUBU 100011→9, AND 100100→0, OR 100101→1, XOR 100110→A, NOR 100111→C, SLT 101010→7, SLTU 101011→B.
  - Mul/div/hilo functs and unknown functs → 4'hF (ALU NOP). Never X.
- Mul/div functs:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - Recognised only when alu_op==4'b1111 and issue=1.
- Hazard: stall = issue & (any mul/div/hilo funct) & busy. A stalled instruction is not accepted.
- Instructions accepted when not stalled:
  - MTHI/MTLO: write rs_val at the next edge.
  - MFHI/MFLO: hilo_sel=1, hilo_rdata=HI/LO in the same cycle.
- FSM states:
  - IDLE: accepting MULT/MULTU → MUL; accepting DIV/DIVU → DIV.
    - Latch |operands| for signed ops; record result signs.
    - count=0.
  - MUL/DIV: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
    - After WIDTH steps → FIX.
  - FIX: apply sign correction, write HI/LO, → IDLE.
- Latency: accept at edge E0. busy=1 for cycles E0+1..E0+WIDTH+1. HI/LO are updated at edge E0+WIDTH+1. A new mul/div can be accepted in the cycle after busy falls.
- Result placement:
  - Multiply: HI:LO = full 2·WIDTH product.
  - Divide: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Signed overflow (MIN/-1): LO=MIN, HI=0.
- Divide by zero: full latency; LO=all-ones; HI=dividend.
- Non-mul/div instructions flow unstalled while busy.
- Reset during MUL/DIV aborts the operation; HI/LO return to 0.

Optional Feature:
- Macro: MULDIV_DIV0_EXC_EN.
- With the macro:
  - Extra output div0_exc (1 bit, reset 0).
  - div0_exc pulses for one cycle at the FIX edge of a divide-by-zero.
  - HI/LO are left unchanged in that case.
- Without the macro: no port; the HI/LO divide-by-zero rule above applies.

Decomposition:
- Shared package mips_alu_pkg holds:
  - ALU control code constants (AND..LUI, NOP=4'hF).
  - Funct constants, including mul/div/hilo.
  - ALUOP_RTYPE=4'b1111.
  - FSM state enum.
- One natural sub-module, muldiv_iter. It holds the iterative datapath and FSM and exposes start/op/operands → done/hi/lo.
- alu_muldiv_ctrl keeps the decode, hazard logic and HI/LO registers.

Test Plan:
- Decode sweep: alu_op=1111 with every listed funct → table code. Funct 111111 → 4'hF. alu_op=0010 → 0010.
- MULT 7 × -3 (0xFFFFFFFD) → busy 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 2 → HI=0x00000001, LO=0xFFFFFFFE.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5 (with macro: HI/LO unchanged, div0_exc one pulse).
- MFHI issued at E0+1 after MULT → stall=1 for 33 cycles. Then hilo_sel=1 with the new HI.
- ADD issued during busy → stall=0.
- rst asserted mid-DIV → busy=0 and HI=LO=0 immediately. The next MULT completes normally.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared MIPS EX-stage definitions: ALU control codes, funct fields, ALUOp and mul/div FSM states.
package mips_alu_pkg;

  localparam logic [3:0] ALUOP_RTYPE = 4'b1111;

  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_SLL  = 4'h3;
  localparam logic [3:0] ALU_SRL  = 4'h4;
  localparam logic [3:0] ALU_SUB  = 4'h6;
  localparam logic [3:0] ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_ADDU = 4'h8;
  localparam logic [3:0] ALU_SUBU = 4'h9;
  localparam logic [3:0] ALU_XOR  = 4'hA;
  localparam logic [3:0] ALU_SLTU = 4'hB;
  localparam logic [3:0] ALU_NOR  = 4'hC;
  localparam logic [3:0] ALU_SRA  = 4'hD;
  localparam logic [3:0] ALU_LUI  = 4'hE;
  localparam logic [3:0] ALU_NOP  = 4'hF;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_DIV  = 2'b10;
  localparam logic [1:0] ST_FIX  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_MUL  = ST_MUL,
    S_DIV  = ST_DIV,
    S_FIX  = ST_FIX
  } md_state_t;

  // Encoded as the low two funct bits of MULT/MULTU/DIV/DIVU.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_hilo(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO);
  endfunction

endpackage

// File: rtl/alu_muldiv_ctrl_muldiv_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring shift-subtract step per cycle,
// magnitudes held internally with sign correction in a final FIX cycle.
module muldiv_iter
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_t        state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             neg_hi, neg_lo, is_div;

  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs, addend;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;

  always_comb begin
    sgn       = (op == MD_MULT) || (op == MD_DIV);
    a_neg     = sgn & a[WIDTH-1];
    b_neg     = sgn & b[WIDTH-1];
    a_abs     = a_neg ? -a : a;
    b_abs     = b_neg ? -b : b;
    addend    = acc_lo[0] ? opnd : '0;
    mul_sum   = {1'b0, acc_hi} + {1'b0, addend};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = div_shift >= {1'b0, opnd};
  end

  // Multiply: acc_lo holds the multiplier and shifts the product in from acc_hi.
  // Divide: acc_lo shifts the dividend out and the quotient in; acc_hi is the remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      is_div <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            is_div <= (op == MD_DIV) || (op == MD_DIVU);
            state  <= ((op == MD_DIV) || (op == MD_DIVU)) ? S_DIV : S_MUL;
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= a_abs;
            opnd   <= b_abs;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= ((op == MD_DIV) || (op == MD_DIVU)) ? a_neg : (a_neg ^ b_neg);
          end
        end
        S_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          count  <= count + 1'b1;
          if (count == LAST) state <= S_FIX;
        end
        S_DIV: begin
          acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          count  <= count + 1'b1;
          if (count == LAST) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          count <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [2*WIDTH-1:0] product, prod_fix;

  always_comb begin
    product  = {acc_hi, acc_lo};
    prod_fix = neg_hi ? -product : product;
    busy     = (state != S_IDLE);
    done     = (state == S_FIX);
    div0     = done & is_div & (opnd == '0);
    hi       = prod_fix[2*WIDTH-1:WIDTH];
    lo       = prod_fix[WIDTH-1:0];
    if (is_div) begin
      hi = neg_hi ? -acc_hi : acc_hi;
      lo = div0 ? '1 : (neg_lo ? -acc_lo : acc_lo);
    end
  end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control with HI/LO registers and mul/div hazard stall.
// Optional MULDIV_DIV0_EXC_EN: adds div0_exc and leaves HI/LO untouched on divide-by-zero.
module alu_muldiv_ctrl
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [3:0]       alu_op,
  input  logic [5:0]       func_code,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       alu_ctrl,
  output logic             hilo_sel,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             busy,
  output logic             stall
`ifdef MULDIV_DIV0_EXC_EN
  ,
  output logic             div0_exc
`endif
);

`ifdef MULDIV_DIV0_EXC_EN
  localparam bit DIV0_HOLD = 1'b1;
`else
  localparam bit DIV0_HOLD = 1'b0;
`endif

  logic [WIDTH-1:0] hi_q, lo_q, md_hi, md_lo;
  logic             md_instr, accept, start, md_done, md_div0, hilo_wr;

  always_comb begin
    alu_ctrl = ALU_NOP;
    if (alu_op != ALUOP_RTYPE) begin
      alu_ctrl = alu_op;
    end else begin
      case (func_code)
        F_SLL:   alu_ctrl = ALU_SLL;
        F_SRL:   alu_ctrl = ALU_SRL;
        F_SRA:   alu_ctrl = ALU_SRA;
        F_ADD:   alu_ctrl = ALU_ADD;
        F_ADDU:  alu_ctrl = ALU_ADDU;
        F_SUB:   alu_ctrl = ALU_SUB;
        F_SUBU:  alu_ctrl = ALU_SUBU;
        F_AND:   alu_ctrl = ALU_AND;
        F_OR:    alu_ctrl = ALU_OR;
        F_XOR:   alu_ctrl = ALU_XOR;
        F_NOR:   alu_ctrl = ALU_NOR;
        F_SLT:   alu_ctrl = ALU_SLT;
        F_SLTU:  alu_ctrl = ALU_SLTU;
        default: alu_ctrl = ALU_NOP;
      endcase
    end
  end

  // Any HI/LO-touching instruction waits out the engine; everything else flows.
  always_comb begin
    md_instr   = issue && (alu_op == ALUOP_RTYPE) && (is_muldiv(func_code) || is_hilo(func_code));
    stall      = ~rst & md_instr & busy;
    accept     = ~rst & md_instr & ~busy;
    start      = accept & is_muldiv(func_code);
    hilo_sel   = accept && ((func_code == F_MFHI) || (func_code == F_MFLO));
    hilo_rdata = '0;
    if (hilo_sel) hilo_rdata = (func_code == F_MFHI) ? hi_q : lo_q;
    hilo_wr    = md_done & ~(DIV0_HOLD & md_div0);
  end

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (md_op_t'(func_code[1:0])),
    .a     (rs_val),
    .b     (rt_val),
    .busy  (busy),
    .done  (md_done),
    .div0  (md_div0),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_wr) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else if (accept && (func_code == F_MTHI)) begin
      hi_q <= rs_val;
    end else if (accept && (func_code == F_MTLO)) begin
      lo_q <= rs_val;
    end
  end

`ifdef MULDIV_DIV0_EXC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div0_exc <= 1'b0;
    else     div0_exc <= md_div0;
  end
`endif

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Randomized self-checking bench for alu_muldiv_ctrl against an arithmetic reference model.
module tb_alu_muldiv_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, issue;
  logic [3:0]    alu_op;
  logic [5:0]    func_code;
  logic [W-1:0]  rs_val, rt_val;
  logic [3:0]    alu_ctrl;
  logic          hilo_sel, busy, stall;
  logic [W-1:0]  hilo_rdata;
`ifdef MULDIV_DIV0_EXC_EN
  logic          div0_exc;
`endif

  alu_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .alu_op     (alu_op),
    .func_code  (func_code),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .alu_ctrl   (alu_ctrl),
    .hilo_sel   (hilo_sel),
    .hilo_rdata (hilo_rdata),
    .busy       (busy),
    .stall      (stall)
`ifdef MULDIV_DIV0_EXC_EN
    ,
    .div0_exc   (div0_exc)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_hi, m_lo;

  logic [5:0] dec_f [13] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                             6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [3:0] dec_c [13] = '{4'h3, 4'h4, 4'hD, 4'h2, 4'h8, 4'h6, 4'h9,
                             4'h0, 4'h1, 4'hA, 4'hC, 4'h7, 4'hB};
  logic [5:0] nop_f [9]  = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13, 6'h3F};
  logic [5:0] rnd_f [6]  = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics via 64-bit integer arithmetic.
  task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    logic [63:0] p, ua, ub;
    longint q, r;
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      6'h18: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h19: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h1A, 6'h1B: begin
        if (b == 0) begin
`ifndef MULDIV_DIV0_EXC_EN
          m_hi = a;
          m_lo = '1;
`endif
        end else if (f == 6'h1A) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          p = ua / ub; m_lo = p[31:0];
          p = ua % ub; m_hi = p[31:0];
        end
      end
      6'h11: m_hi = a;
      6'h13: m_lo = a;
      default: ;
    endcase
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic read_hilo(input string tag);
    issue = 1'b1; alu_op = 4'hF; func_code = 6'h10;
    #1;
    check({tag, "_mfhi_sel"}, hilo_sel, 1);
    check({tag, "_hi"}, hilo_rdata, m_hi);
    @(posedge clk); #1;
    func_code = 6'h12;
    #1;
    check({tag, "_lo"}, hilo_rdata, m_lo);
    @(posedge clk); #1;
    issue = 1'b0;
  endtask

  task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic md, exp_div0;
    md = (f[5:2] == 4'b0110);
    exp_div0 = (f == 6'h1A || f == 6'h1B) && (b == 0);
    issue = 1'b1; alu_op = 4'hF; func_code = f; rs_val = a; rt_val = b;
    #1;
    check({tag, "_nostall"}, stall, 0);
    @(posedge clk); #1;
    issue = 1'b0;
    if (md) begin
      n = 0;
      while (busy && n < 200) begin
        n++;
        @(posedge clk); #1;
      end
      check({tag, "_busy_cycles"}, n, W + 1);
`ifdef MULDIV_DIV0_EXC_EN
      check({tag, "_div0_exc"}, div0_exc, exp_div0);
      @(posedge clk); #1;
      check({tag, "_div0_exc_low"}, div0_exc, 0);
`else
      if (exp_div0) check({tag, "_idle_after"}, busy, 0);
`endif
    end
    model(f, a, b);
    read_hilo(tag);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [5:0] f;
    logic [3:0] op;
    m_hi = '0; m_lo = '0;
    rst = 1'b1; issue = 1'b1; alu_op = 4'hF; func_code = 6'h10; rs_val = '0; rt_val = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_hilo_sel", hilo_sel, 0);
    check("rst_rdata", hilo_rdata, 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; issue = 1'b0;
    read_hilo("after_rst");

    for (int i = 0; i < 13; i++) begin
      alu_op = 4'hF; func_code = dec_f[i]; #1;
      check($sformatf("dec_f%0h", dec_f[i]), alu_ctrl, dec_c[i]);
    end
    for (int i = 0; i < 9; i++) begin
      alu_op = 4'hF; func_code = nop_f[i]; #1;
      check($sformatf("dec_nop_f%0h", nop_f[i]), alu_ctrl, 4'hF);
    end
    alu_op = 4'b0010; func_code = 6'h20; #1;
    check("dec_pass_0010", alu_ctrl, 4'b0010);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 14));
      f  = rnd_f[$urandom_range(0, 5)];
      issue = 1'b1; alu_op = op; func_code = f; #1;
      check("dec_pass_rand", alu_ctrl, op);
      check("nonrtype_nostall", stall, 0);
      @(posedge clk); #1;
      check("nonrtype_noengine", busy, 0);
    end
    issue = 1'b0;

    run_md("mult", 6'h18, 32'd7, 32'hFFFF_FFFD);
    run_md("multu", 6'h19, 32'hFFFF_FFFF, 32'd2);
    run_md("div", 6'h1A, 32'hFFFF_FFF9, 32'd2);
    run_md("divu0", 6'h1B, 32'd5, 32'd0);
    run_md("div0s", 6'h1A, 32'hFFFF_FF00, 32'd0);
    run_md("divovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("mthi", 6'h11, 32'h1234_5678, 32'd0);
    run_md("mtlo", 6'h13, 32'h9ABC_DEF0, 32'd0);

    // MFHI right behind a MULT must wait for the new HI.
    issue = 1'b1; alu_op = 4'hF; func_code = 6'h18; rs_val = 32'd1000; rt_val = 32'hFFFF_FFF0;
    @(posedge clk); #1;
    func_code = 6'h10; rs_val = '0;
    #1;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(posedge clk); #2;
    end
    check("mfhi_stall_cycles", n, W + 1);
    model(6'h18, 32'd1000, 32'hFFFF_FFF0);
    check("mfhi_after_sel", hilo_sel, 1);
    check("mfhi_after_hi", hilo_rdata, m_hi);
    @(posedge clk); #1;
    issue = 1'b0;

    // ALU op flows during busy; MTHI during busy is held off.
    issue = 1'b1; alu_op = 4'hF; func_code = 6'h1A; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    func_code = 6'h20; rs_val = 32'hDEAD_BEEF; #1;
    check("add_busy", busy, 1);
    check("add_nostall", stall, 0);
    check("add_ctrl", alu_ctrl, 4'h2);
    @(posedge clk); #1;
    func_code = 6'h11; #1;
    check("mthi_stall", stall, 1);
    check("mthi_no_sel", hilo_sel, 0);
    @(posedge clk); #1;
    issue = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check("div_busy_done", busy, 0);
`ifdef MULDIV_DIV0_EXC_EN
    @(posedge clk); #1;
`endif
    model(6'h1A, 32'd100, 32'd7);
    read_hilo("div_with_traffic");

    for (int i = 0; i < 30; i++) begin
      run_md($sformatf("rand%0d", i), rnd_f[$urandom_range(0, 5)], pick(), pick());
    end

    // Reset mid-divide aborts it and clears HI/LO.
    issue = 1'b1; alu_op = 4'hF; func_code = 6'h1A; rs_val = 32'hFFFF_FF9C; rt_val = 32'd7;
    @(posedge clk); #1;
    func_code = 6'h10;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1; #1;
    check("midrst_busy", busy, 0);
    check("midrst_stall", stall, 0);
    check("midrst_hilo_sel", hilo_sel, 0);
    @(posedge clk); #1;
    rst = 1'b0; issue = 1'b0;
    m_hi = '0; m_lo = '0;
    read_hilo("midrst");
    run_md("mult_after_rst", 6'h18, 32'hFFFF_F000, 32'h0001_2345);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
